key_event_fifo_avs: RTL and testbench

- FPGA-to-HPS direction of the pushbutton/LED PIO path. It debounces the active-low pushbuttons and timestamps every press and release.
- Events are queued in a small FIFO. The HPS drains the FIFO through a 32-bit Avalon-MM slave with read latency 1.
- Sits in the top level beside the Qsys system and connects to an Avalon-MM bridge port in place of the raw pushbutton PIO.

---
 rtl/key_evt_pkg.sv | 29 ++
 rtl/key_debounce.sv | 53 +++++
 rtl/key_event_fifo_avs.sv | 173 +++++++++++++++++
 tb/tb_key_event_fifo_avs.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// Shared constants for the key event FIFO: register map, event word layout, STATUS packing.
package key_evt_pkg;

  localparam int unsigned TS_W          = 29;
  localparam int unsigned EVT_KEY_LSB   = 30;
  localparam int unsigned EVT_KEY_W     = 2;
  localparam int unsigned EVT_PRESS_BIT = 29;
  localparam int unsigned EVT_TS_LSB    = 0;

  typedef enum logic [1:0] {
    ADDR_STATUS = 2'd0,
    ADDR_DATA   = 2'd1,
    ADDR_CLEAR  = 2'd2,
    ADDR_IRQ_EN = 2'd3
  } reg_addr_e;

  typedef struct packed {
    logic [EVT_KEY_W-1:0] key;
    logic                 press;
    logic [TS_W-1:0]      ts;
  } key_evt_t;

  function automatic logic [31:0] pack_status(input logic [7:0] cnt, input logic empty,
                                              input logic full, input logic ovf,
                                              input logic [7:0] drop);
    return {8'h00, drop, 5'b0_0000, ovf, full, empty, cnt};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-FF synchronizer plus stability counter; level is 1 while pressed.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic level,
  output logic change
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic             change_q, change_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d   = {sync_q[0], key_n};
    level_d  = level_q;
    change_d = 1'b0;
    cnt_d    = '0;
    // Count only while the synchronized level disagrees with the accepted one.
    if (~sync_q[1] != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d  = ~level_q;
        change_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '1;
      level_q  <= 1'b0;
      change_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      level_q  <= level_d;
      change_q <= change_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level  = level_q;
  assign change = change_q;

endmodule

// File: rtl/key_event_fifo_avs.sv
// Debounced, timestamped pushbutton event FIFO drained over a read-latency-1 Avalon-MM slave.
// Optional interrupt output and IRQ_EN register enabled by defining KEY_EVT_IRQ_EN.
module key_event_fifo_avs
  import key_evt_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TICK_DIV        = 50000,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [1:0]          avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  output logic                irq
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(TICK_DIV - 1);

  logic [NUM_KEYS-1:0] level, change;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .key_n  (key_n[g]),
      .level  (level[g]),
      .change (change[g])
    );
  end

  logic [DIV_W-1:0]    div_q, div_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic [NUM_KEYS-1:0] pend_q, pend_d, pend_press_q, pend_press_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          drop_q, drop_d;
  logic [31:0]         readdata_q, readdata_d;
  logic                irq_q, irq_d;
  logic [31:0]         mem_q [FIFO_DEPTH];

  reg_addr_e addr;
  key_evt_t  evt;
  logic      push, push_press, pop, wr_en, empty, full, clear;
  logic [EVT_KEY_W-1:0] push_key;

`ifdef KEY_EVT_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata[31:1];
`else
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata[31:1];
`endif

  always_comb begin
    addr  = reg_addr_e'(avs_address);
    empty = (count_q == '0);
    full  = (count_q == FULL_CNT);
    div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
    ts_d  = (div_q == DIV_MAX) ? ts_q + 1'b1 : ts_q;

    // Lowest pending index wins; a fresh change re-arms a key even if it is served now.
    push       = 1'b0;
    push_key   = '0;
    push_press = 1'b0;
    pend_d     = pend_q;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (pend_q[i] && !push) begin
        push       = 1'b1;
        push_key   = EVT_KEY_W'(i);
        push_press = pend_press_q[i];
        pend_d[i]  = 1'b0;
      end
    end
    pend_d       = pend_d | change;
    pend_press_d = (pend_press_q & ~change) | (level & change);

    evt.key   = push_key;
    evt.press = push_press;
    evt.ts    = ts_q;

    pop   = avs_read && (addr == ADDR_DATA) && !empty;
    wr_en = push && (!full || pop);
    clear = avs_write && (addr == ADDR_CLEAR) && avs_writedata[0];

    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop) count_d = count_q + 1'b1;
    if (!wr_en && pop) count_d = count_q - 1'b1;

    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clear) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (push && full && !pop) begin
      ovf_d  = 1'b1;
      drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
    end

    readdata_d = '0;
    if (avs_read) begin
      case (addr)
        ADDR_STATUS: readdata_d = pack_status(8'(count_q), empty, full, ovf_q, drop_q);
        ADDR_DATA:   if (!empty) readdata_d = mem_q[rd_ptr_q];
`ifdef KEY_EVT_IRQ_EN
        ADDR_IRQ_EN: readdata_d = {31'b0, irq_en_q};
`endif
        default:     readdata_d = '0;
      endcase
    end

`ifdef KEY_EVT_IRQ_EN
    irq_en_d = (avs_write && (addr == ADDR_IRQ_EN)) ? avs_writedata[0] : irq_en_q;
    irq_d    = irq_en_d && (count_d != '0);
`else
    irq_d    = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q        <= '0;
      ts_q         <= '0;
      pend_q       <= '0;
      pend_press_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      drop_q       <= '0;
      readdata_q   <= '0;
      irq_q        <= 1'b0;
`ifdef KEY_EVT_IRQ_EN
      irq_en_q     <= 1'b0;
`endif
    end else begin
      div_q        <= div_d;
      ts_q         <= ts_d;
      pend_q       <= pend_d;
      pend_press_q <= pend_press_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      drop_q       <= drop_d;
      readdata_q   <= readdata_d;
      irq_q        <= irq_d;
`ifdef KEY_EVT_IRQ_EN
      irq_en_q     <= irq_en_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= evt;
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_key_event_fifo_avs.sv
// Randomized self-checking bench for key_event_fifo_avs against an event-level FIFO model.
module tb_key_event_fifo_avs;

  localparam int unsigned NK    = 3;
  localparam int unsigned DB    = 4;
  localparam int unsigned TD    = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LAT   = DB + 3;

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_DATA   = 2'd1;
  localparam logic [1:0] A_CLEAR  = 2'd2;
  localparam logic [1:0] A_IRQEN  = 2'd3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic [1:0]    avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic          irq;

  key_event_fifo_avs #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DB),
    .TICK_DIV       (TD),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_n        (key_n),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; the DUT timestamp is edges/TD.
  int unsigned edge_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;
  end

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic        m_ovf = 1'b0;
  logic [7:0]  m_drop = '0;
  logic [NK-1:0] kstate = '0;

  function automatic logic [31:0] evt_word(input int unsigned k, input logic press,
                                           input int unsigned pedge);
    logic [31:0] kk;
    logic [28:0] ts;
    kk = k;
    ts = 29'((pedge - 1) / TD);
    return {kk[1:0], press, ts};
  endfunction

  function automatic void model_push(input logic [31:0] w);
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    else begin
      m_ovf = 1'b1;
      if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
    end
  endfunction

  function automatic logic [31:0] status_exp();
    int unsigned n;
    n = exp_q.size();
    return {8'h00, m_drop, 5'b0, m_ovf, (n == DEPTH), (n == 0), 8'(n)};
  endfunction

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 32'h0;
    return exp_q.pop_front();
  endfunction

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d        = avs_readdata;
  endtask

  task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic key_drive(input logic [NK-1:0] mask, output int unsigned e0);
    @(negedge clk);
    key_n = key_n ^ mask;
    e0    = edge_cnt + 1;
  endtask

  // Toggle keys, predict the pushes (lower index first, one per cycle), wait for them to land.
  task automatic key_change(input logic [NK-1:0] mask);
    int unsigned e0, rank;
    key_drive(mask, e0);
    rank = 0;
    for (int i = 0; i < NK; i++) begin
      if (mask[i]) begin
        kstate[i] = ~kstate[i];
        model_push(evt_word(i, kstate[i], e0 + LAT + rank));
        rank++;
      end
    end
    idle(DB + 10);
  endtask

  task automatic key_rand();
    logic [NK-1:0] m;
    m = '0;
    m[$urandom_range(0, NK - 1)] = 1'b1;
    key_change(m);
  endtask

  task automatic release_all_and_drain();
    logic [31:0] d, e;
    if (kstate != '0) key_change(kstate);
    while (exp_q.size() != 0) begin
      e = pop_exp();
      avs_rd(A_DATA, d);
      checks++;
      if (d !== e) begin failures++; $display("FAIL drain_data got=%h exp=%h", d, e); end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++;
    if (avs_readdata !== 32'h0) begin failures++; $display("FAIL reset_readdata got=%h exp=0", avs_readdata); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    @(negedge clk);
    reset_n = 1'b1;
    avs_rd(A_STATUS, d);
    checks++;
    if (d !== 32'h0000_0100) begin failures++; $display("FAIL reset_status got=%h exp=00000100", d); end
    avs_rd(A_DATA, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL empty_data got=%h exp=0", d); end
    avs_rd(A_STATUS, d);
    checks++;
    if (d !== 32'h0000_0100) begin failures++; $display("FAIL empty_pop_status got=%h exp=00000100", d); end
  endtask

  task automatic test_single_press();
    logic [31:0] d, e;
    key_change(3'b001);
    idle(6);
    avs_rd(A_STATUS, d);
    e = status_exp();
    checks++;
    if (d !== e) begin failures++; $display("FAIL single_status got=%h exp=%h", d, e); end
    e = pop_exp();
    avs_rd(A_DATA, d);
    checks++;
    if (d !== e) begin failures++; $display("FAIL single_data got=%h exp=%h", d, e); end
    avs_rd(A_STATUS, d);
    checks++;
    if (d !== 32'h0000_0100) begin failures++; $display("FAIL single_after_status got=%h exp=00000100", d); end
    repeat (6) begin
      key_rand();
      e = pop_exp();
      avs_rd(A_DATA, d);
      checks++;
      if (d !== e) begin failures++; $display("FAIL rand_data got=%h exp=%h", d, e); end
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d, e;
    int unsigned g;
    g = $urandom_range(1, DB - 1);
    @(negedge clk);
    key_n[1] = ~key_n[1];
    repeat (g) @(negedge clk);
    key_n[1] = ~key_n[1];
    idle(20);
    avs_rd(A_STATUS, d);
    e = status_exp();
    checks++;
    if (d !== e) begin failures++; $display("FAIL glitch_status got=%h exp=%h len=%0d", d, e, g); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] w0, w1, e0, e1;
    release_all_and_drain();
    key_change(3'b101);
    e0 = pop_exp();
    e1 = pop_exp();
    avs_rd(A_DATA, w0);
    avs_rd(A_DATA, w1);
    checks++;
    if (w0 !== e0) begin failures++; $display("FAIL simul_first got=%h exp=%h", w0, e0); end
    checks++;
    if (w1 !== e1) begin failures++; $display("FAIL simul_second got=%h exp=%h", w1, e1); end
    checks++;
    if ((w1[28:0] - w0[28:0]) > 29'd1) begin
      failures++; $display("FAIL simul_ts_gap got=%0d exp<=1", w1[28:0] - w0[28:0]);
    end
    key_change(3'b101);
    release_all_and_drain();
  endtask

  task automatic test_overflow();
    logic [31:0] d, e;
    release_all_and_drain();
    repeat (10) key_rand();
    avs_wr(A_DATA, $urandom);
    avs_wr(A_STATUS, $urandom);
    avs_rd(A_STATUS, d);
    e = status_exp();
    checks++;
    if (d !== e) begin failures++; $display("FAIL ovf_status got=%h exp=%h", d, e); end
    checks++;
    if (d[23:16] !== 8'd2) begin failures++; $display("FAIL ovf_drop_cnt got=%0d exp=2", d[23:16]); end
    for (int i = 0; i < DEPTH; i++) begin
      e = pop_exp();
      avs_rd(A_DATA, d);
      checks++;
      if (d !== e) begin failures++; $display("FAIL ovf_data%0d got=%h exp=%h", i, d, e); end
    end
    avs_rd(A_STATUS, d);
    e = status_exp();
    checks++;
    if (d !== e) begin failures++; $display("FAIL ovf_sticky got=%h exp=%h", d, e); end
    avs_wr(A_CLEAR, 32'h1);
    m_ovf  = 1'b0;
    m_drop = '0;
    avs_rd(A_STATUS, d);
    e = status_exp();
    checks++;
    if (d !== e) begin failures++; $display("FAIL clear_status got=%h exp=%h", d, e); end
    avs_rd(A_CLEAR, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL clear_read got=%h exp=0", d); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d, e, w;
    int unsigned e0, k;
    logic [NK-1:0] m;
    release_all_and_drain();
    repeat (DEPTH) key_rand();
    avs_rd(A_STATUS, d);
    e = status_exp();
    checks++;
    if (d !== e) begin failures++; $display("FAIL full_status got=%h exp=%h", d, e); end
    k = $urandom_range(0, NK - 1);
    m = '0;
    m[k] = 1'b1;
    key_drive(m, e0);
    kstate[k] = ~kstate[k];
    w = evt_word(k, kstate[k], e0 + LAT);
    while (edge_cnt < e0 + LAT - 1) @(negedge clk);
    avs_address = A_DATA;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
    e = pop_exp();
    exp_q.push_back(w);
    checks++;
    if (d !== e) begin failures++; $display("FAIL fullpp_data got=%h exp=%h", d, e); end
    avs_rd(A_STATUS, d);
    e = status_exp();
    checks++;
    if (d !== e) begin failures++; $display("FAIL fullpp_status got=%h exp=%h", d, e); end
    release_all_and_drain();
  endtask

  task automatic test_irq();
    logic [31:0] d, e;
    release_all_and_drain();
    avs_wr(A_IRQEN, 32'h1);
    avs_rd(A_IRQEN, d);
`ifdef KEY_EVT_IRQ_EN
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL irq_en_read got=%h exp=1", d); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_empty got=%b exp=0", irq); end
    key_rand();
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", irq); end
    e = pop_exp();
    avs_rd(A_DATA, d);
    checks++;
    if (d !== e) begin failures++; $display("FAIL irq_data got=%h exp=%h", d, e); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_after_pop got=%b exp=0", irq); end
`else
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL irq_en_read got=%h exp=0", d); end
    key_rand();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_tied got=%b exp=0", irq); end
    release_all_and_drain();
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, e;
    key_rand();
    @(negedge clk);
    avs_address = A_STATUS;
    avs_read    = 1'b1;
    key_n[$urandom_range(0, NK - 1)] ^= 1'b1;
    repeat (3) @(negedge clk);
    e = status_exp();
    checks++;
    if (avs_readdata !== e) begin failures++; $display("FAIL pre_reset_status got=%h exp=%h", avs_readdata, e); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (avs_readdata !== 32'h0) begin failures++; $display("FAIL midreset_readdata got=%h exp=0", avs_readdata); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL midreset_irq got=%b exp=0", irq); end
    avs_read = 1'b0;
    key_n    = '1;
    exp_q.delete();
    m_ovf  = 1'b0;
    m_drop = '0;
    kstate = '0;
    idle(2);
    reset_n = 1'b1;
    idle(20);
    avs_rd(A_STATUS, d);
    checks++;
    if (d !== 32'h0000_0100) begin failures++; $display("FAIL postreset_status got=%h exp=00000100", d); end
    avs_rd(A_IRQEN, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL postreset_irq_en got=%h exp=0", d); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_overflow();
    test_full_push_pop();
    test_irq();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
